// File: rtl/instruction_fetch_if.sv
// Fetch-stage bundle: instruction-memory req/ack channel plus decode-facing instruction register.
// Latency: none (wires only).
// Backpressure: decode holds Stall; memory completes a request by raising IMemAck.
interface instruction_fetch_if #(
    parameter int PC_W    = 16,
    parameter int INSTR_W = 24
);
    logic               Stall;
    logic               BranchTaken;
    logic [PC_W-1:0]    BranchTarget;
    logic               IMemReq;
    logic [PC_W-1:0]    IMemAddr;
    logic               IMemAck;
    logic [INSTR_W-1:0] IMemData;
    logic [INSTR_W-1:0] Instr;
    logic [PC_W-1:0]    InstrPC;
    logic               InstrValid;
    logic [3:0]         Opcode;

    // Fetch stage side
    modport master (
        input  Stall, BranchTaken, BranchTarget, IMemAck, IMemData,
        output IMemReq, IMemAddr, Instr, InstrPC, InstrValid, Opcode
    );

    // Environment side (memory, decode, execute)
    modport slave (
        output Stall, BranchTaken, BranchTarget, IMemAck, IMemData,
        input  IMemReq, IMemAddr, Instr, InstrPC, InstrValid, Opcode
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, req/ack instruction-memory transaction, instruction register with branch flush.
// Latency: InstrValid one cycle after REQ entry with zero-wait memory; one instruction per 2 cycles.
// Backpressure: Stall holds a valid instruction and blocks the next fetch; BranchTaken overrides it.
module instruction_fetch #(
    parameter int              PC_W     = 16,
    parameter int              INSTR_W  = 24,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                 Clock,
    input  logic                 Reset,
    instruction_fetch_if.master  fe
);

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_VALID = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    pend_pc_q, pend_pc_d;
    logic [PC_W-1:0]    addr_q, addr_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    instr_pc_q, instr_pc_d;
    logic               instr_valid_q, instr_valid_d;

    // Next-state, PC and instruction-register update
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_pc_d     = pend_pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;

        case (state_q)
            ST_REQ: begin
                if (fe.IMemAck) begin
                    if (fe.BranchTaken) begin
                        // Word belongs to the wrong path: drop it and refetch at the target
                        pc_d    = fe.BranchTarget;
                        state_d = ST_REQ;
                    end else begin
                        instr_d       = fe.IMemData;
                        instr_pc_d    = addr_q;
                        pc_d          = pc_q + PC_W'(1);
                        instr_valid_d = 1'b1;
                        state_d       = ST_VALID;
                    end
                end else if (fe.BranchTaken) begin
                    // Request cannot be withdrawn; remember the target until memory answers
                    pend_pc_d = fe.BranchTarget;
                    state_d   = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fe.IMemAck) begin
                    // A redirect arriving with the ack is the latest one, so it wins
                    pc_d    = fe.BranchTaken ? fe.BranchTarget : pend_pc_q;
                    state_d = ST_REQ;
                end else if (fe.BranchTaken) begin
                    pend_pc_d = fe.BranchTarget;
                end
            end
            ST_VALID: begin
                if (fe.BranchTaken) begin
                    instr_valid_d = 1'b0;
                    pc_d          = fe.BranchTarget;
                    state_d       = ST_REQ;
                end else if (!fe.Stall) begin
                    instr_valid_d = 1'b0;
                    state_d       = ST_REQ;
                end
            end
            default: begin
                instr_valid_d = 1'b0;
                state_d       = ST_REQ;
            end
        endcase
    end

    // Fetch address is captured only on REQ entry so it stays stable for the whole request
    always_comb begin
        addr_d = addr_q;
        if (state_d == ST_REQ) begin
            addr_d = pc_d;
        end
    end

    // State and datapath registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q       <= ST_REQ;
            pc_q          <= RESET_PC;
            pend_pc_q     <= '0;
            addr_q        <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_pc_q     <= pend_pc_d;
            addr_q        <= addr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    // Request is gated by Reset so an in-flight transaction is dropped immediately
    assign fe.IMemReq    = !Reset && ((state_q == ST_REQ) || (state_q == ST_DRAIN));
    assign fe.IMemAddr   = addr_q;
    assign fe.Instr      = instr_q;
    assign fe.InstrPC    = instr_pc_q;
    assign fe.InstrValid = instr_valid_q;
    assign fe.Opcode     = instr_valid_q ? instr_q[INSTR_W-1 -: 4] : 4'b0000;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios then randomized traffic against a transaction-level model.
// Latency: model predicts outputs one clock after each set of inputs.
// Backpressure: bench drives Stall and random memory wait states.
module tb_instruction_fetch;
    localparam int PC_W    = 16;
    localparam int INSTR_W = 24;

    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    instruction_fetch_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    instruction_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(16'h0000)) u_dut (
        .Clock (Clock),
        .Reset (Reset),
        .fe    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: outstanding request, whether its data will be thrown away, and the held instruction
    bit          m_req;
    bit          m_doomed;
    bit          m_valid;
    logic [15:0] m_addr;
    logic [15:0] m_redirect;
    logic [15:0] m_ipc;
    logic [23:0] m_instr;

    bit          hash_mode  = 1'b0;
    bit          force_data = 1'b0;
    logic [23:0] forced_word = 24'h0;

    function automatic logic [23:0] mem_word(input logic [15:0] a);
        if (!hash_mode) return {8'hA0, a};
        return {a[7:0] ^ a[15:8] ^ 8'h3C, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_req = 1'b1; m_doomed = 1'b0; m_valid = 1'b0;
        m_addr = 16'h0000; m_redirect = 16'h0; m_ipc = 16'h0; m_instr = 24'h0;
    endtask

    task automatic zero_inputs();
        bus.Stall = 1'b0; bus.BranchTaken = 1'b0; bus.BranchTarget = '0;
        bus.IMemAck = 1'b0; bus.IMemData = '0;
    endtask

    task automatic check_outputs();
        chk("imem_req", bus.IMemReq, m_req);
        if (m_req) chk("imem_addr", bus.IMemAddr, m_addr);
        chk("instr_valid", bus.InstrValid, m_valid);
        chk("opcode", bus.Opcode, m_valid ? m_instr[23:20] : 4'h0);
        chk("instr", bus.Instr, m_instr);
        chk("instr_pc", bus.InstrPC, m_ipc);
    endtask

    // Called at a falling edge: drive inputs, let the rising edge happen, advance model, check at next falling edge
    task automatic cycle(input bit stall, input bit br, input logic [15:0] tgt, input bit ack);
        bit          ack_e;
        logic [23:0] word;
        ack_e = ack && m_req;
        if (force_data)  word = forced_word;
        else if (ack_e)  word = mem_word(m_addr);
        else             word = 24'($urandom);
        bus.Stall = stall; bus.BranchTaken = br; bus.BranchTarget = tgt;
        bus.IMemAck = ack_e; bus.IMemData = word;
        @(posedge Clock);
        if (m_valid) begin
            if (br) begin
                m_valid = 1'b0; m_req = 1'b1; m_addr = tgt;
            end else if (!stall) begin
                m_valid = 1'b0; m_req = 1'b1; m_addr = m_ipc + 16'd1;
            end
        end else if (!m_doomed) begin
            if (ack_e && !br) begin
                m_instr = word; m_ipc = m_addr; m_valid = 1'b1; m_req = 1'b0;
            end else if (ack_e && br) begin
                m_addr = tgt;
            end else if (br) begin
                m_doomed = 1'b1; m_redirect = tgt;
            end
        end else begin
            if (ack_e) begin
                m_doomed = 1'b0; m_addr = br ? tgt : m_redirect;
            end else if (br) begin
                m_redirect = tgt;
            end
        end
        @(negedge Clock);
        check_outputs();
    endtask

    // Zero-wait traffic until either a request at address a, or a valid instruction from a
    task automatic run_to(input bit want_valid, input logic [15:0] a, input bit stall, input int budget);
        bit hit = 1'b0;
        for (int i = 0; i <= budget; i++) begin
            if (want_valid ? (m_valid && m_ipc == a) : (m_req && !m_doomed && m_addr == a)) begin
                hit = 1'b1;
                break;
            end
            if (i < budget) cycle(stall, 1'b0, 16'h0, 1'b1);
        end
        chk("run_to_reached", hit, 1'b1);
    endtask

    // Asserted a little after a falling edge; checks the asynchronous effect, returns at a falling edge
    task automatic async_reset();
        #2 Reset = 1'b1;
        zero_inputs();
        #1;
        chk("rst_req_low", bus.IMemReq, 1'b0);
        chk("rst_valid_low", bus.InstrValid, 1'b0);
        chk("rst_opcode", bus.Opcode, 4'h0);
        chk("rst_instr", bus.Instr, 24'h0);
        chk("rst_instr_pc", bus.InstrPC, 16'h0);
        @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        model_reset();
        #1;
        check_outputs();
    endtask

    initial begin
        Reset = 1'b1;
        zero_inputs();
        model_reset();
        @(negedge Clock);
        chk("init_req_low", bus.IMemReq, 1'b0);
        chk("init_valid", bus.InstrValid, 1'b0);
        chk("init_opcode", bus.Opcode, 4'h0);
        chk("init_instr", bus.Instr, 24'h0);
        chk("init_instr_pc", bus.InstrPC, 16'h0);
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        check_outputs();
        chk("first_req", bus.IMemReq, 1'b1);
        chk("first_addr", bus.IMemAddr, 16'h0000);

        // Zero-wait sequential fetch up to address 5
        run_to(1'b0, 16'd5, 1'b0, 40);

        // Three wait cycles at address 5
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 16'h0, 1'b0);
            chk("wait_addr_hold", bus.IMemAddr, 16'd5);
            chk("wait_req_hold", bus.IMemReq, 1'b1);
        end
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        chk("wait_instr", bus.Instr, 24'hA00005);
        chk("wait_valid", bus.InstrValid, 1'b1);

        // Stall four cycles on the instruction from 7
        run_to(1'b1, 16'd7, 1'b0, 20);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 16'h0, 1'b1);
            chk("stall_pc_hold", bus.InstrPC, 16'd7);
            chk("stall_no_req", bus.IMemReq, 1'b0);
        end
        cycle(1'b0, 1'b0, 16'h0, 1'b0);
        chk("stall_next_addr", bus.IMemAddr, 16'd8);

        // Branch while valid and stalled flushes
        run_to(1'b1, 16'd8, 1'b1, 10);
        cycle(1'b1, 1'b1, 16'h0040, 1'b0);
        chk("flush_valid", bus.InstrValid, 1'b0);
        chk("flush_opcode", bus.Opcode, 4'h0);
        chk("flush_addr", bus.IMemAddr, 16'h0040);

        // Branch during a pending request: old address held until ack, stale word dropped
        cycle(1'b0, 1'b1, 16'h0100, 1'b0);
        chk("drain_addr0", bus.IMemAddr, 16'h0040);
        cycle(1'b0, 1'b0, 16'h0, 1'b0);
        chk("drain_addr1", bus.IMemAddr, 16'h0040);
        force_data = 1'b1; forced_word = 24'h123456;
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        force_data = 1'b0;
        chk("drain_redirect", bus.IMemAddr, 16'h0100);
        chk("drain_no_leak", bus.Instr === 24'h123456, 1'b0);
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        chk("drain_new_instr", bus.Instr, 24'hA00100);

        // PC wrap from FFFF, then reset during an open request
        cycle(1'b0, 1'b1, 16'hFFFF, 1'b0);
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        chk("wrap_instr_pc", bus.InstrPC, 16'hFFFF);
        cycle(1'b0, 1'b0, 16'h0, 1'b0);
        chk("wrap_addr", bus.IMemAddr, 16'h0000);
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        cycle(1'b0, 1'b0, 16'h0, 1'b0);
        chk("pre_reset_addr", bus.IMemAddr, 16'h0001);
        async_reset();
        chk("restart_addr", bus.IMemAddr, 16'h0000);

        // Randomized traffic with hashed memory contents
        hash_mode = 1'b1;
        for (int i = 0; i < 600; i++) begin
            bit          r_stall, r_br, r_ack;
            logic [15:0] r_tgt;
            r_stall = ($urandom_range(0, 2) == 0);
            r_br    = ($urandom_range(0, 7) == 0);
            r_ack   = ($urandom_range(0, 2) != 0);
            r_tgt   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            cycle(r_stall, r_br, r_tgt, r_ack);
            if (i == 300) async_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
